// File: rtl/vip_stream_gen_if.sv
// Pixel-side bundle of the VIP stream generator: upstream read FIFO handshake
// plus the raster output stream consumed by window/filter blocks.
interface vip_stream_gen_if;
  logic       pix_rd;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic [7:0] out_data;
  logic       out_de;
  logic       out_en;
  logic       frame_start;
  logic       underflow;

  modport master (
    output pix_rd,
    output out_data,
    output out_de,
    output out_en,
    output frame_start,
    output underflow,
    input  pix_data,
    input  pix_valid
  );

  modport slave (
    input  pix_rd,
    input  out_data,
    input  out_de,
    input  out_en,
    input  frame_start,
    input  underflow,
    output pix_data,
    output pix_valid
  );
endinterface

// File: rtl/vip_stream_gen.sv
// Raster pixel-stream transmitter: fixed-geometry active/blanking timing with
// a 1-cycle-latency FIFO fetch and FILL_VAL substitution on underflow.
module vip_stream_gen #(
  parameter int unsigned COL      = 1280,
  parameter int unsigned ROW      = 720,
  parameter int unsigned H_BLANK  = 370,
  parameter int unsigned V_BLANK  = 30,
  parameter logic [7:0]  FILL_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output logic             busy_o,
  vip_stream_gen_if.master vs_if
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] COL_W  = 16'(COL);
  localparam logic [15:0] ROW_W  = 16'(ROW);
  localparam logic [15:0] H_LAST = 16'(COL + H_BLANK - 1);
  localparam logic [15:0] V_LAST = 16'(ROW + V_BLANK - 1);

  state_t      state_q, state_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic        stop_req_q, stop_req_d;
  logic        out_de_q, out_en_q, frame_start_q;

  logic        act_s;
  logic        line_s;
  logic        first_s;

  // Next-state, counter advance and pre-register strobes.
  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    stop_req_d = stop_req_q;

    act_s   = (state_q == RUN) && (h_cnt_q < COL_W) && (v_cnt_q < ROW_W);
    line_s  = (state_q == RUN) && (v_cnt_q < ROW_W);
    first_s = act_s && (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);

    case (state_q)
      IDLE: begin
        h_cnt_d    = 16'd0;
        v_cnt_d    = 16'd0;
        stop_req_d = 1'b0;
        if (enable_i) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A stop request is sticky: re-enabling cannot cancel it mid-frame.
        if (!enable_i) begin
          stop_req_d = 1'b1;
        end else begin
          stop_req_d = stop_req_q;
        end
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = 16'd0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = 16'd0;
            if (stop_req_q || !enable_i) begin
              state_d    = IDLE;
              stop_req_d = 1'b0;
            end else begin
              state_d = RUN;
            end
          end else begin
            v_cnt_d = v_cnt_q + 16'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        h_cnt_d    = 16'd0;
        v_cnt_d    = 16'd0;
        stop_req_d = 1'b0;
      end
    endcase
  end

  // State, counters and the 1-cycle-delayed output strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      h_cnt_q       <= 16'd0;
      v_cnt_q       <= 16'd0;
      stop_req_q    <= 1'b0;
      out_de_q      <= 1'b0;
      out_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      stop_req_q    <= stop_req_d;
      out_de_q      <= act_s;
      out_en_q      <= line_s;
      frame_start_q <= first_s;
    end
  end

  // pix_data/pix_valid arrive registered by the FIFO in the cycle after pix_rd,
  // which is exactly the cycle out_de_q is high, so they are gated, not re-registered.
  assign vs_if.pix_rd      = act_s;
  assign vs_if.out_de      = out_de_q;
  assign vs_if.out_en      = out_en_q;
  assign vs_if.frame_start = frame_start_q;
  assign vs_if.out_data    = out_de_q ? (vs_if.pix_valid ? vs_if.pix_data : FILL_VAL) : 8'h00;
  assign vs_if.underflow   = out_de_q & ~vs_if.pix_valid;
  assign busy_o            = (state_q == RUN);

endmodule
